dp_ram_init: RTL and testbench
==============================

// Module: dp_ram_init
// PURPOSE
//   Synchronous two-port RAM: port A read/write with byte-lane write strobes, port B read-only.
//   Self-clears all contents after every reset via an internal init sweep; 1-cycle registered reads
//   with valid strobes. Main data store between CPU-side (A) and peripheral/DMA-side (B) masters.
// PARAMETERS
//   ADDR_WIDTH  16  address bits; DEPTH = 2**ADDR_WIDTH words
//   DATA_WIDTH  8   word width in bits; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes
// PORTS
//   clk       in   1           clock, all state on rising edge
//   rst_n     in   1           asynchronous active-low reset
//   ready     out  1           1 = init sweep done, ports accept requests
//   a_cs      in   1           port A request
//   a_we      in   1           port A 1 = write, 0 = read (qualified by a_cs)
//   a_be      in   NB          port A byte-lane write enables (bit i -> data[8i+7:8i])
//   a_addr    in   ADDR_WIDTH  port A address
//   a_wdata   in   DATA_WIDTH  port A write data
//   a_rdata   out  DATA_WIDTH  port A read data
//   a_rvalid  out  1           port A read data valid, 1-cycle pulse
//   b_cs      in   1           port B read request
//   b_addr    in   ADDR_WIDTH  port B address
//   b_rdata   out  DATA_WIDTH  port B read data
//   b_rvalid  out  1           port B read data valid, 1-cycle pulse
//   a_perr    out  1           port A parity error (RAM_PARITY_EN only)
//   b_perr    out  1           port B parity error (RAM_PARITY_EN only)
// BEHAVIOUR
//   Reset (rst_n low, async): ready=0, a_rdata=b_rdata=0, a_rvalid=b_rvalid=0, perr=0; FSM->INIT, init_cnt=0.
//   FSM states: INIT, RUN.
//   INIT: each cycle writes 0 (and correct parity) to mem[init_cnt], init_cnt++; at init_cnt==DEPTH-1
//     go to RUN. ready goes high on the edge that enters RUN: DEPTH rising edges after rst_n deasserts.
//   INIT: a_cs/b_cs ignored; no writes, no rvalid, rdata held at 0.
//   RUN, port A write (a_cs&a_we): on edge, lanes with a_be[i]=1 updated, others kept; a_rvalid stays 0.
//     a_be=0 -> no change. a_rdata not updated by writes.
//   RUN, port A read (a_cs&!a_we): a_rdata=mem[a_addr] and a_rvalid=1 on the next edge (latency 1).
//   RUN, port B read (b_cs): same timing on b_rdata/b_rvalid. Back-to-back reads every cycle supported.
//   rvalid deasserts the cycle after a pulse unless a new read was issued; rdata holds its last value.
//   Collision (A write + B read, same addr, same cycle): write-first; b_rdata = merged new word
//     (written lanes new, unwritten lanes old).
//   A write then A read, same addr, next cycle: returns new data (no hazard).
//   Addresses wrap naturally modulo DEPTH; no out-of-range case.
//   Reset mid-operation: outputs cleared immediately, in-flight reads dropped (no rvalid), INIT re-runs,
//     all prior contents lost.
// CONFIGURATION
//   RAM_PARITY_EN defined: one even-parity bit stored per byte lane (array width DATA_WIDTH+NB); parity
//     generated on every write incl. INIT; checked on read; a_perr/b_perr = OR of lane mismatches,
//     asserted only in the same cycle as the matching rvalid, else 0.
//   RAM_PARITY_EN undefined: no parity storage, a_perr/b_perr ports absent; otherwise identical.
// TESTING (bench params ADDR_WIDTH=4, DATA_WIDTH=16)
//   Release rst_n -> ready=0 for 15 edges, 1 on 16th; A reads 0..15 -> all 0x0000, a_rvalid 1 cycle after each cs.
//   A write 0xA5C3 addr 3 be=11, A read addr 3 -> a_rdata=0xA5C3, a_rvalid=1 exactly next cycle; B read same -> same.
//   Write 0xFFFF addr 5, then 0x1234 be=01 -> read 0xFF34; be=00 write 0x0000 -> still 0xFF34, no rvalid.
//   A write 0xBEEF be=10 addr 7 (old 0x0000) + B read addr 7 same cycle -> b_rdata=0xBE00, b_rvalid=1.
//   Write addrs 0..15, drop rst_n mid-cycle -> ready/rvalid/rdata 0 immediately; after re-init all reads 0.
//   RAM_PARITY_EN: flip stored parity bit lane 0 addr 2 via hierarchy, A read addr 2 -> a_perr=1 with a_rvalid;
//     unmodified addr -> a_perr=0.

Source files
------------

// File: rtl/dp_ram_init.sv
// dp_ram_init: synchronous two-port RAM (A read/write with byte strobes,
// B read-only) that clears its whole array with an init sweep after reset.
// Optional per-lane even parity is enabled by defining RAM_PARITY_EN.
//
// state | meaning
// INIT  | sweeping zeros into every word, requests ignored, ready=0
// RUN   | normal operation, ready=1
module dp_ram_init #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    output logic                      ready,
    input  logic                      a_cs,
    input  logic                      a_we,
    input  logic [DATA_WIDTH/8-1:0]   a_be,
    input  logic [ADDR_WIDTH-1:0]     a_addr,
    input  logic [DATA_WIDTH-1:0]     a_wdata,
    output logic [DATA_WIDTH-1:0]     a_rdata,
    output logic                      a_rvalid,
    input  logic                      b_cs,
    input  logic [ADDR_WIDTH-1:0]     b_addr,
    output logic [DATA_WIDTH-1:0]     b_rdata,
    output logic                      b_rvalid
`ifdef RAM_PARITY_EN
    ,
    output logic                      a_perr,
    output logic                      b_perr
`endif
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef RAM_PARITY_EN
    localparam int W     = DATA_WIDTH + NB;
`else
    localparam int W     = DATA_WIDTH;
`endif

    typedef enum logic {INIT, RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   init_cnt;

    logic [W-1:0]            mem [DEPTH];

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [W-1:0]            wr_word;
    logic [DATA_WIDTH-1:0]   merged;
    logic [W-1:0]            a_old;
    logic [W-1:0]            a_word;
    logic [W-1:0]            b_word;

`ifdef RAM_PARITY_EN
    // Even parity: the stored bit makes each lane plus its parity bit even.
    function automatic logic [NB-1:0] gen_par(input logic [DATA_WIDTH-1:0] d);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    function automatic logic par_err(input logic [W-1:0] w);
        return |(w[W-1:DATA_WIDTH] ^ gen_par(w[DATA_WIDTH-1:0]));
    endfunction
`endif

    // Write-port mux (init sweep or A write) and write-first read forwarding.
    always_comb begin
        a_old = mem[a_addr];
        merged = '0;
        for (int i = 0; i < NB; i++)
            merged[8*i +: 8] = a_be[i] ? a_wdata[8*i +: 8] : a_old[8*i +: 8];

        wr_en   = 1'b0;
        wr_addr = a_addr;
`ifdef RAM_PARITY_EN
        wr_word = {gen_par(merged), merged};
`else
        wr_word = merged;
`endif
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_addr = init_cnt;
            wr_word = '0;
        end else if (a_cs && a_we && (|a_be)) begin
            wr_en = 1'b1;
        end

        a_word = a_old;
        if (state == RUN && a_cs && a_we && a_addr == b_addr)
            b_word = wr_word;
        else
            b_word = mem[b_addr];
    end

    // Array storage; no reset because the init sweep clears it.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_word;
    end

    // Control FSM with registered read outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= '0;
            ready    <= 1'b0;
            a_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rdata  <= '0;
            b_rvalid <= 1'b0;
`ifdef RAM_PARITY_EN
            a_perr   <= 1'b0;
            b_perr   <= 1'b0;
`endif
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
`ifdef RAM_PARITY_EN
            a_perr   <= 1'b0;
            b_perr   <= 1'b0;
`endif
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == {ADDR_WIDTH{1'b1}}) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (a_cs && !a_we) begin
                        a_rdata  <= a_word[DATA_WIDTH-1:0];
                        a_rvalid <= 1'b1;
`ifdef RAM_PARITY_EN
                        a_perr   <= par_err(a_word);
`endif
                    end
                    if (b_cs) begin
                        b_rdata  <= b_word[DATA_WIDTH-1:0];
                        b_rvalid <= 1'b1;
`ifdef RAM_PARITY_EN
                        b_perr   <= par_err(b_word);
`endif
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_dp_ram_init.sv
// Testbench for dp_ram_init (ADDR_WIDTH=4, DATA_WIDTH=16).
module tb_dp_ram_init;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic        a_cs, a_we;
    logic [1:0]  a_be;
    logic [3:0]  a_addr;
    logic [15:0] a_wdata, a_rdata;
    logic        a_rvalid;
    logic        b_cs;
    logic [3:0]  b_addr;
    logic [15:0] b_rdata;
    logic        b_rvalid;
`ifdef RAM_PARITY_EN
    logic        a_perr, b_perr;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        a_cs;
        logic        a_we;
        logic [1:0]  a_be;
        logic [3:0]  a_addr;
        logic [15:0] a_wdata;
        logic        b_cs;
        logic [3:0]  b_addr;
        logic [15:0] exp_a;
        logic [15:0] exp_b;
    } vec_t;

    typedef struct {
        logic        v;
        logic [15:0] d;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    vec_t tbl[12];
    vec_t idle;

    dp_ram_init #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .ready(ready),
        .a_cs(a_cs), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_cs(b_cs), .b_addr(b_addr), .b_rdata(b_rdata), .b_rvalid(b_rvalid)
`ifdef RAM_PARITY_EN
        , .a_perr(a_perr), .b_perr(b_perr)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        a_cs = v.a_cs; a_we = v.a_we; a_be = v.a_be; a_addr = v.a_addr;
        a_wdata = v.a_wdata; b_cs = v.b_cs; b_addr = v.b_addr;
    endtask

    // Drive one cycle, push expectations, then pop and compare one edge later.
    task automatic drive(input vec_t v);
        exp_t ea, eb;
        apply(v);
        ea.v = v.a_cs & ~v.a_we; ea.d = v.exp_a; qa.push_back(ea);
        eb.v = v.b_cs;           eb.d = v.exp_b; qb.push_back(eb);
        @(posedge clk); #1;
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk1("a_rvalid", a_rvalid, ea.v);
        if (ea.v) chk16("a_rdata", a_rdata, ea.d);
        chk1("b_rvalid", b_rvalid, eb.v);
        if (eb.v) chk16("b_rdata", b_rdata, eb.d);
`ifdef RAM_PARITY_EN
        chk1("a_perr", a_perr, 1'b0);
        chk1("b_perr", b_perr, 1'b0);
`endif
    endtask

    // Release reset and count edges until ready; requests are held active to prove they are ignored.
    task automatic init_wait();
        vec_t v;
        v = idle; v.a_cs = 1'b1; v.b_cs = 1'b1; v.a_addr = 4'd1; v.b_addr = 4'd2;
        apply(v);
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            chk1("init_ready", ready, (k == 16));
            chk1("init_a_rvalid", a_rvalid, 1'b0);
            chk1("init_b_rvalid", b_rvalid, 1'b0);
            chk16("init_a_rdata", a_rdata, 16'h0000);
        end
        apply(idle);
    endtask

    task automatic read_all_zero();
        vec_t v;
        for (int i = 0; i < 16; i++) begin
            v = idle;
            v.a_cs = 1'b1; v.a_addr = i[3:0];
            v.b_cs = 1'b1; v.b_addr = 4'(15 - i);
            drive(v);
        end
        drive(idle);
    endtask

    initial begin
        idle = '{a_cs:1'b0, a_we:1'b0, a_be:2'b00, a_addr:4'd0, a_wdata:16'h0,
                 b_cs:1'b0, b_addr:4'd0, exp_a:16'h0, exp_b:16'h0};
        //          cs    we    be     addr   wdata     bcs   baddr  expA      expB
        tbl[0]  = '{1'b1, 1'b1, 2'b11, 4'd3, 16'hA5C3, 1'b0, 4'd0, 16'h0,    16'h0};
        tbl[1]  = '{1'b1, 1'b0, 2'b00, 4'd3, 16'h0,    1'b1, 4'd3, 16'hA5C3, 16'hA5C3};
        tbl[2]  = '{1'b1, 1'b1, 2'b11, 4'd5, 16'hFFFF, 1'b0, 4'd0, 16'h0,    16'h0};
        tbl[3]  = '{1'b1, 1'b1, 2'b01, 4'd5, 16'h1234, 1'b0, 4'd0, 16'h0,    16'h0};
        tbl[4]  = '{1'b1, 1'b0, 2'b00, 4'd5, 16'h0,    1'b0, 4'd0, 16'hFF34, 16'h0};
        tbl[5]  = '{1'b1, 1'b1, 2'b00, 4'd5, 16'h0000, 1'b0, 4'd0, 16'h0,    16'h0};
        tbl[6]  = '{1'b1, 1'b0, 2'b00, 4'd5, 16'h0,    1'b0, 4'd0, 16'hFF34, 16'h0};
        tbl[7]  = '{1'b1, 1'b1, 2'b10, 4'd7, 16'hBEEF, 1'b1, 4'd7, 16'h0,    16'hBE00};
        tbl[8]  = '{1'b1, 1'b0, 2'b00, 4'd7, 16'h0,    1'b1, 4'd5, 16'hBE00, 16'hFF34};
        tbl[9]  = '{1'b1, 1'b0, 2'b00, 4'd3, 16'h0,    1'b1, 4'd3, 16'hA5C3, 16'hA5C3};
        tbl[10] = '{1'b1, 1'b1, 2'b11, 4'd9, 16'h5555, 1'b0, 4'd0, 16'h0,    16'h0};
        tbl[11] = '{1'b0, 1'b0, 2'b00, 4'd0, 16'h0,    1'b0, 4'd0, 16'h0,    16'h0};

        rst_n = 1'b0;
        apply(idle);
        #12;
        chk1("rst_ready", ready, 1'b0);
        chk1("rst_a_rvalid", a_rvalid, 1'b0);
        chk1("rst_b_rvalid", b_rvalid, 1'b0);
        chk16("rst_a_rdata", a_rdata, 16'h0000);
        chk16("rst_b_rdata", b_rdata, 16'h0000);
        @(posedge clk); #1;
        init_wait();
        read_all_zero();

        for (int i = 0; i < 12; i++) drive(tbl[i]);
        // Last reads were addr 3; a write and idle cycles must not disturb rdata.
        chk16("hold_a_rdata", a_rdata, 16'hA5C3);
        chk16("hold_b_rdata", b_rdata, 16'hA5C3);
        chk1("hold_a_rvalid", a_rvalid, 1'b0);

`ifdef RAM_PARITY_EN
        begin
            vec_t v;
            dut.mem[2][16] = ~dut.mem[2][16];
            v = idle; v.a_cs = 1'b1; v.a_addr = 4'd2;
            apply(v);
            @(posedge clk); #1;
            chk1("par_a_rvalid", a_rvalid, 1'b1);
            chk1("par_a_perr", a_perr, 1'b1);
            v.a_addr = 4'd3;
            apply(v);
            @(posedge clk); #1;
            chk1("par_ok_a_rvalid", a_rvalid, 1'b1);
            chk1("par_ok_a_perr", a_perr, 1'b0);
            apply(idle);
            @(posedge clk); #1;
            chk1("par_idle_a_perr", a_perr, 1'b0);
        end
`endif

        // Fill every word, then reset in the middle of a cycle with a read pending.
        begin
            vec_t v;
            for (int i = 0; i < 16; i++) begin
                v = idle; v.a_cs = 1'b1; v.a_we = 1'b1; v.a_be = 2'b11;
                v.a_addr = i[3:0]; v.a_wdata = {12'hC00, i[3:0]};
                drive(v);
            end
            v = idle; v.a_cs = 1'b1; v.a_addr = 4'd4; v.exp_a = 16'hC004;
            v.b_cs = 1'b1; v.b_addr = 4'd9; v.exp_b = 16'hC009;
            drive(v);
            v.a_addr = 4'd5; v.b_addr = 4'd6;
            apply(v);
            #3;
            rst_n = 1'b0;
            #1;
            chk1("mid_rst_ready", ready, 1'b0);
            chk1("mid_rst_a_rvalid", a_rvalid, 1'b0);
            chk1("mid_rst_b_rvalid", b_rvalid, 1'b0);
            chk16("mid_rst_a_rdata", a_rdata, 16'h0000);
            chk16("mid_rst_b_rdata", b_rdata, 16'h0000);
            @(posedge clk); #1;
            chk1("mid_rst_drop_a", a_rvalid, 1'b0);
            chk1("mid_rst_drop_b", b_rvalid, 1'b0);
            init_wait();
            read_all_zero();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
